// File: rtl/pair_mul_arbiter_pkg.sv
// Shared types for the two-requester signed pair multiplier:
// operand pair, result record, priority pointer states and the product helper.
package types;

  localparam int PIPE_DEPTH = 2;
  localparam int OP_W       = 9;
  localparam int PROD_W     = 2 * OP_W;

  // Operand pair offered by a requester: sel0 is x, sel1 is y.
  typedef struct packed {
    logic signed [OP_W-1:0] product0_sel0;
    logic signed [OP_W-1:0] product0_sel1;
  } product0;

  // Pipeline output record: full-precision product and issuing requester.
  typedef struct packed {
    logic signed [PROD_W-1:0] product;
    logic                     tag;
  } result_t;

  // Round-robin pointer: which requester wins when both are valid.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_t;

  // Full 9x9 signed product; operands are sign-extended before multiplying
  // so the 18-bit result never wraps.
  function automatic logic signed [PROD_W-1:0] mul_pair(input product0 p);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'(p.product0_sel0);
    b = PROD_W'(p.product0_sel1);
    return a * b;
  endfunction

endpackage

// File: rtl/pair_mul_arbiter_pipe.sv
// Two-stage signed multiplier shared by both requesters. Stage 1 captures the
// operands and tag, stage 2 captures the product and tag. A single enable
// advances both stages together, so bubbles are preserved during a stall.
module pair_mul_pipe
  import types::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    load_valid,
  input  product0 load_pair,
  input  logic    load_tag,
  output logic    res_valid,
  output result_t res,
  output logic    busy
);

  logic    s1_valid;
  product0 s1_pair;
  logic    s1_tag;

  logic    s2_valid;
  result_t s2_res;

  // Stage 1: take the granted pair (or a bubble) whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pair  <= '0;
      s1_tag   <= 1'b0;
    end else if (en) begin
      s1_valid <= load_valid;
      if (load_valid) begin
        s1_pair <= load_pair;
        s1_tag  <= load_tag;
      end
    end
  end

  // Stage 2: multiply the stage-1 operands; data only changes for real entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res.product <= mul_pair(s1_pair);
        s2_res.tag     <= s1_tag;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res       = s2_res;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: rtl/pair_mul_arbiter.sv
// Round-robin arbiter in front of a shared two-stage signed multiplier.
// Two requesters offer operand pairs; one is granted per advancing cycle and
// the result comes back two cycles later tagged with the requester index.
module pair_mul_arbiter
  import types::*;
#(
  parameter int RR_START = 0
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     req0_valid,
  input  product0                  req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  product0                  req1_data,
  output logic                     req1_ready,
  output logic                     res_valid,
  output logic signed [PROD_W-1:0] res_data,
  output logic                     res_tag,
  input  logic                     res_ready,
  output logic                     busy
);

  localparam pri_t PRI_RESET = (RR_START == 1) ? PRI1 : PRI0;

  pri_t    pri_q;
  pri_t    pri_d;
  logic    en;
  logic    grant_valid;
  logic    grant_tag;
  logic    accept;
  product0 load_pair;
  result_t res;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign en = !res_valid || res_ready;

  // Priority pointer register.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      pri_q <= PRI_RESET;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Grant selection, ready generation and pointer update on an accepted pair.
  always_comb begin
    pri_d       = pri_q;
    grant_valid = req0_valid || req1_valid;
    grant_tag   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_tag = (pri_q == PRI1);
    end else begin
      grant_tag = req1_valid;
    end
    if (en && !system1000_rst && grant_valid) begin
      req0_ready = !grant_tag;
      req1_ready = grant_tag;
      pri_d      = grant_tag ? PRI0 : PRI1;
    end
  end

  assign accept    = req0_ready || req1_ready;
  assign load_pair = grant_tag ? req1_data : req0_data;

  pair_mul_pipe u_pipe (
    .clk       (system1000),
    .rst       (system1000_rst),
    .en        (en),
    .load_valid(accept),
    .load_pair (load_pair),
    .load_tag  (grant_tag),
    .res_valid (res_valid),
    .res       (res),
    .busy      (busy)
  );

  assign res_data = res.product;
  assign res_tag  = res.tag;

endmodule

// File: tb/tb_pair_mul_arbiter.sv
// Self-checking bench for pair_mul_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pair_mul_arbiter;
  import types::*;

  localparam int RR_START = 0;

  logic                     system1000;
  logic                     system1000_rst;
  logic                     req0_valid;
  product0                  req0_data;
  logic                     req0_ready;
  logic                     req1_valid;
  product0                  req1_data;
  logic                     req1_ready;
  logic                     res_valid;
  logic signed [PROD_W-1:0] res_data;
  logic                     res_tag;
  logic                     res_ready;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model: pointer plus the two pipeline slots as plain values.
  int m_ptr;
  bit m1v, m1t, m2v, m2t;
  int m1x, m1y, m2p;

  pair_mul_arbiter #(.RR_START(RR_START)) dut (
    .system1000    (system1000),
    .system1000_rst(system1000_rst),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_tag       (res_tag),
    .res_ready     (res_ready),
    .busy          (busy)
  );

  initial system1000 = 1'b0;
  always #5 system1000 = ~system1000;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model before the
  // edge, then advance the model by the rules of the arbiter and pipeline.
  task automatic step(input bit rst, input bit v0, input int x0, input int y0,
                      input bit v1, input int x1, input int y1, input bit rr);
    bit en, g_tag, e_r0, e_r1;
    int got_data;
    system1000_rst            = rst;
    req0_valid                = v0;
    req0_data.product0_sel0   = 9'(x0);
    req0_data.product0_sel1   = 9'(y0);
    req1_valid                = v1;
    req1_data.product0_sel0   = 9'(x1);
    req1_data.product0_sel1   = 9'(y1);
    res_ready                 = rr;
    #1;
    en    = !m2v || rr;
    g_tag = (v0 && v1) ? (m_ptr == 1) : v1;
    e_r0  = !rst && en && (v0 || v1) && !g_tag;
    e_r1  = !rst && en && (v0 || v1) && g_tag;
    check("res_valid", int'(res_valid), int'(m2v));
    check("busy", int'(busy), int'(m1v || m2v));
    check("req0_ready", int'(req0_ready), int'(e_r0));
    check("req1_ready", int'(req1_ready), int'(e_r1));
    if (m2v) begin
      got_data = res_data;
      check("res_data", got_data, m2p);
      check("res_tag", int'(res_tag), int'(m2t));
    end
    @(posedge system1000);
    if (rst) begin
      m1v = 0; m2v = 0; m2p = 0; m2t = 0; m_ptr = RR_START;
    end else if (en) begin
      m2v = m1v;
      if (m1v) begin
        m2p = m1x * m1y;
        m2t = m1t;
      end
      m1v = e_r0 || e_r1;
      if (e_r0) begin
        m1x = x0; m1y = y0; m1t = 0; m_ptr = 1;
      end else if (e_r1) begin
        m1x = x1; m1y = y1; m1t = 1; m_ptr = 0;
      end
    end
    @(negedge system1000);
  endtask

  task automatic applyIdle(input bit rr);
    step(0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic checkResult(input string name, input int v, input int d, input int t);
    int got_data;
    got_data = res_data;
    check({name, "_valid"}, int'(res_valid), v);
    if (v != 0) begin
      check({name, "_data"}, got_data, d);
      check({name, "_tag"}, int'(res_tag), t);
    end
  endtask

  initial begin
    int exp_tag[4];
    int exp_dat[4];
    int ext_dat[3];
    int gap_v[6];
    int gap_b[6];

    exp_tag = '{0, 1, 0, 1};
    exp_dat = '{1, 4, 1, 4};
    ext_dat = '{65536, -65280, 65025};
    gap_v   = '{0, 1, 0, 0, 1, 0};
    gap_b   = '{1, 1, 0, 1, 1, 0};

    system1000_rst = 1'b1;
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    req0_data = '0; req1_data = '0;
    @(posedge system1000);
    @(posedge system1000);
    @(negedge system1000);
    m1v = 0; m2v = 0; m2p = 0; m2t = 0; m_ptr = RR_START;
    m1x = 0; m1y = 0; m1t = 0;

    // Reset state.
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_tag", int'(res_tag), 0);
    check("rst_req0_ready", int'(req0_ready), 0);

    // Single request: (3,-4) gives -12 two edges later.
    step(0, 1, 3, -4, 0, 0, 0, 1);
    applyIdle(1);
    checkResult("single", 1, -12, 0);
    applyIdle(1);

    // Two entries in flight, then a one-cycle reset flushes them.
    step(0, 1, 5, 5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 6, 6, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("midrst_res_valid", int'(res_valid), 0);
    check("midrst_busy", int'(busy), 0);

    // Contention right after reset: requester RR_START first, then alternate.
    step(0, 1, 1, 1, 1, 2, 2, 1);
    check("cont_first_empty", int'(res_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 1, 2, 2, 1);
      checkResult($sformatf("cont%0d", i), 1, exp_dat[i], exp_tag[i]);
    end
    applyIdle(1);
    applyIdle(1);

    // Extreme operands.
    step(0, 0, 0, 0, 1, -256, -256, 1);
    step(0, 0, 0, 0, 1, -256, 255, 1);
    checkResult("ext0", 1, ext_dat[0], 1);
    step(0, 0, 0, 0, 1, 255, 255, 1);
    checkResult("ext1", 1, ext_dat[1], 1);
    applyIdle(1);
    checkResult("ext2", 1, ext_dat[2], 1);
    applyIdle(1);

    // Backpressure: fill both stages, stall three cycles, then release.
    step(0, 1, 2, 3, 0, 0, 0, 1);
    step(0, 1, 4, 5, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 7, 7, 0, 0, 0, 0);
      check($sformatf("stall%0d_req0_ready", i), int'(req0_ready), 0);
      checkResult($sformatf("stall%0d", i), 1, 6, 0);
    end
    applyIdle(1);
    checkResult("release", 1, 20, 0);
    applyIdle(1);
    check("release_drained", int'(res_valid), 0);

    // Idle gap of two cycles between pairs.
    step(0, 1, 1, 2, 0, 0, 0, 1);
    check("gap0_busy", int'(busy), gap_b[0]);
    check("gap0_valid", int'(res_valid), gap_v[0]);
    for (int i = 1; i < 6; i++) begin
      if (i == 3) step(0, 1, 3, 3, 0, 0, 0, 1);
      else applyIdle(1);
      check($sformatf("gap%0d_busy", i), int'(busy), gap_b[i]);
      check($sformatf("gap%0d_valid", i), int'(res_valid), gap_v[i]);
      if (gap_v[i] != 0) begin
        check($sformatf("gap%0d_data", i), int'(res_data), (i == 1) ? 2 : 9);
      end
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
